onchip_ram_pipe: RTL and testbench

- Parametrised single-port on-chip RAM with an Avalon-MM slave interface.
- Next generation of the SoC's fixed 4x32 on-chip memory. Generalised in data width, depth and init file.
- Adds pipelined reads with readdatavalid, a clock-enable stall, a write freeze, and out-of-range detection.
- Sits on the Nios II data bus as scratch/shared storage for game state.

---
 rtl/onchip_ram_pipe.sv | 112 +++++++++++
 tb/tb_onchip_ram_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_pipe.sv
// Single-port on-chip RAM with an Avalon-MM slave: pipelined reads, clken stall, write freeze and
// sticky out-of-range flag. Define ONCHIP_RAM_PIPE_OUTREG_EN for a second read output stage.
module onchip_ram_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter string       INIT_FILE = "onchip_ram_pipe.hex"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic                  clken,
  input  logic                  freeze,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  err_oob
);

  localparam int unsigned NumLanes = DATA_W / 8;

  logic              en;
  logic              req;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  assign en          = clken & ~reset_req;
  assign req         = chipselect & (read | write);
  assign waitrequest = req & ~en;
  assign accept      = req & en;
  assign wr_acc      = accept & write;
  // A combined read+write performs only the write.
  assign rd_acc      = accept & read & ~write;
  assign in_range    = 32'(address) < DEPTH;

  // Contents come from the configuration image only; reset leaves them untouched.
  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_acc && in_range && !freeze) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (byteenable[i]) begin
          mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[address];
    end
  end

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;

  // Whole pipeline freezes while en is low, so a valid beat is presented again unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (en) begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rd_word;
      end
    end
  end

`ifdef ONCHIP_RAM_PIPE_OUTREG_EN
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s1_data_q;
      end
    end
  end

  assign readdatavalid = s2_valid_q;
  assign readdata      = s2_data_q;
`else
  assign readdatavalid = s1_valid_q;
  assign readdata      = s1_data_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      err_oob <= 1'b0;
    end else if (accept && !in_range) begin
      err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_onchip_ram_pipe.sv
// Scoreboard bench for onchip_ram_pipe: reads push expected data, a monitor pops on each new beat.
module tb_onchip_ram_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_req;
  logic        clken;
  logic        freeze;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        err_oob;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  onchip_ram_pipe #(
    .DATA_W(32),
    .DEPTH (200),
    .ADDR_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reset_req    (reset_req),
    .clken        (clken),
    .freeze       (freeze),
    .chipselect   (chipselect),
    .read         (read),
    .write        (write),
    .address      (address),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .waitrequest  (waitrequest),
    .err_oob      (err_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a beat counts only on an edge where the pipeline advanced; otherwise it must hold.
  initial begin
    logic        en_e;
    logic [31:0] last;
    logic [31:0] e;
    last = '0;
    forever begin
      @(posedge clk);
      en_e = clken && !reset_req;
      #1;
      if (readdatavalid) begin
        if (en_e) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %h expected no beat", readdata);
          end else begin
            e = exp_q.pop_front();
            check("read_beat", readdata, e);
          end
          last = readdata;
        end else begin
          check("held_beat", readdata, last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    address    = a;
    byteenable = be;
    writedata  = d;
    cyc(1);
    idle_inputs();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = a;
    exp_q.push_back(e);
    cyc(1);
    idle_inputs();
  endtask

  initial begin
    reset      = 1'b1;
    reset_req  = 1'b0;
    clken      = 1'b1;
    freeze     = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    idle_inputs();
    cyc(2);
    check("reset_valid", {31'b0, readdatavalid}, 32'h0);
    check("reset_data", readdata, 32'h0);
    check("reset_err", {31'b0, err_oob}, 32'h0);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) wr(8'(a), 4'hF, 32'hA000_0000 + 32'(a));

    // Streaming reads with a 3-cycle clken drop while address 4 is requested.
    for (int a = 0; a < 8; a++) begin
      if (a == 4) begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 8'd4;
        clken      = 1'b0;
        repeat (3) begin
          #0;
          check("stall_waitrequest", {31'b0, waitrequest}, 32'h1);
          cyc(1);
        end
        clken = 1'b1;
        #0;
        check("run_waitrequest", {31'b0, waitrequest}, 32'h0);
      end
      rd(8'(a), 32'hA000_0000 + 32'(a));
    end
    cyc(3);

    wr(8'd5, 4'hF, 32'hAABB_CCDD);
    wr(8'd5, 4'b0101, 32'h1122_3344);
    rd(8'd5, 32'hAA22_CC44);
    cyc(2);

    wr(8'd3, 4'hF, 32'h0);
    freeze = 1'b1;
    wr(8'd3, 4'hF, 32'hDEAD_BEEF);
    freeze = 1'b0;
    rd(8'd3, 32'h0);
    cyc(2);
    check("freeze_err", {31'b0, err_oob}, 32'h0);

    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    address    = 8'd7;
    byteenable = 4'hF;
    writedata  = 32'h5;
    cyc(1);
    idle_inputs();
    rd(8'd7, 32'h5);
    cyc(2);

    rd(8'd250, 32'h0);
    cyc(2);
    check("oob_err_set", {31'b0, err_oob}, 32'h1);
    wr(8'd210, 4'hF, 32'hFFFF_FFFF);
    rd(8'd0, 32'hA000_0000);
    rd(8'd1, 32'hA000_0001);
    rd(8'd2, 32'hA000_0002);
    rd(8'd3, 32'h0);
    rd(8'd4, 32'hA000_0004);
    rd(8'd5, 32'hAA22_CC44);
    rd(8'd6, 32'hA000_0006);
    rd(8'd7, 32'h5);
    rd(8'd210, 32'h0);
    cyc(3);
    check("oob_err_sticky", {31'b0, err_oob}, 32'h1);

    // Reset lands on live reads; anything still in flight must vanish.
    rd(8'd0, 32'hA000_0000);
    rd(8'd1, 32'hA000_0001);
    rd(8'd2, 32'hA000_0002);
    rd(8'd3, 32'h0);
    reset      = 1'b1;
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 8'd4;
    cyc(1);
    address    = 8'd5;
    cyc(1);
    check("midrst_valid", {31'b0, readdatavalid}, 32'h0);
    check("midrst_data", readdata, 32'h0);
    check("midrst_err", {31'b0, err_oob}, 32'h0);
    exp_q.delete();
    reset = 1'b0;
    idle_inputs();
    cyc(5);
    rd(8'd2, 32'hA000_0002);
    cyc(4);
    check("drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
